// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline widths, PC increment and reset/bubble defaults
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return {a[INSTR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats hold, bubble keeps pc fields
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] pc,
  input  logic [INSTR_W-1:0] pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] q_pc,
  output logic [INSTR_W-1:0] q_pc_plus4,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc       <= '0;
      q_pc_plus4 <= '0;
      q_instr    <= NOP_INSTR;
      q_valid    <= 1'b0;
    end else if (bubble) begin
      q_instr    <= NOP_INSTR;
      q_valid    <= 1'b0;
    end else if (!hold) begin
      q_pc       <= pc;
      q_pc_plus4 <= pc_plus4;
      q_instr    <= instr;
      q_valid    <= 1'b1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, next-PC select and IF/ID capture; IF_PERF_CNT_EN adds fetch/bubble counters
module if_stage
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  input  logic               jump,
  input  logic [INSTR_W-1:0] jump_target,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_id_pc,
  output logic [INSTR_W-1:0] if_id_pc_plus4,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);
  logic [INSTR_W-1:0] pc_q, pc_plus4, pc_d, target;
  logic redirect, bubble, hold;
  assign redirect  = branch_taken | jump;
  assign target    = word_align(branch_taken ? branch_target : jump_target);
  assign pc_plus4  = pc_q + PC_INC;
  assign bubble    = redirect | flush;
  assign hold      = stall & ~bubble;
  assign pc_d      = redirect ? target : hold ? pc_q : pc_plus4;
  assign imem_addr = pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .bubble     (bubble),
    .pc         (pc_q),
    .pc_plus4   (pc_plus4),
    .instr      (imem_instr),
    .q_pc       (if_id_pc),
    .q_pc_plus4 (if_id_pc_plus4),
    .q_instr    (if_id_instr),
    .q_valid    (if_id_valid)
  );
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      else if (!stall) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage fetch, stall, redirect, flush, wrap and async reset
module tb_if_stage;
  logic        clk = 0;
  logic        rst_n = 0, w_rst_n = 0;
  logic        stall = 0, flush = 0, branch_taken = 0, jump = 0;
  logic [31:0] branch_target = 0, jump_target = 0;
  logic [31:0] imem_addr, imem_instr, if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_id_instr;
  logic        w_valid;
  logic [31:0] mem [0:255];
  int tests = 0, fails = 0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt, w_pf, w_pb;
`endif
  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr[9:2]];
  assign w_instr    = mem[w_addr[9:2]];

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jump(1'b0), .jump_target(32'h0),
    .imem_addr(w_addr), .imem_instr(w_instr),
    .if_id_pc(w_pc), .if_id_pc_plus4(w_pc4),
    .if_id_instr(w_id_instr), .if_id_valid(w_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(w_pf), .perf_bubble_cnt(w_pb)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h0); end
    tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    tests++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
    tests++; if (if_id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h exp 0", if_id_pc_plus4); end
`ifdef IF_PERF_CNT_EN
    tests++; if (perf_fetch_cnt !== 0 || perf_bubble_cnt !== 0) begin fails++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_bubble_cnt); end
`endif
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fetch();
    tick();
    tests++; if (if_id_instr !== 32'h2008_0005) begin fails++; $display("FAIL fetch1_instr got %h exp 20080005", if_id_instr); end
    tests++; if (if_id_pc !== 32'h0) begin fails++; $display("FAIL fetch1_pc got %h exp 0", if_id_pc); end
    tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL fetch1_addr got %h exp 4", imem_addr); end
    tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL fetch1_valid got %b exp 1", if_id_valid); end
    tick();
    tests++; if (if_id_instr !== 32'h2009_0003) begin fails++; $display("FAIL fetch2_instr got %h exp 20090003", if_id_instr); end
    tests++; if (if_id_pc !== 32'h4) begin fails++; $display("FAIL fetch2_pc got %h exp 4", if_id_pc); end
    tests++; if (if_id_pc_plus4 !== 32'h8) begin fails++; $display("FAIL fetch2_pc4 got %h exp 8", if_id_pc_plus4); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL stall_addr[%0d] got %h exp 8", i, imem_addr); end
      tests++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'h2009_0003 || if_id_valid !== 1'b1) begin
        fails++; $display("FAIL stall_ifid[%0d] got %h/%h/%b exp 4/20090003/1", i, if_id_pc, if_id_instr, if_id_valid); end
    end
    stall = 0;
    tick();
    tests++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'hA000_0002) begin fails++; $display("FAIL stall_resume got %h/%h exp 8/a0000002", if_id_pc, if_id_instr); end
    tests++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL stall_resume_addr got %h exp c", imem_addr); end
  endtask

  task automatic test_branch_stall();
    branch_taken = 1; branch_target = 32'h40; stall = 1;
    tick();
    branch_taken = 0; stall = 0;
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL br_addr got %h exp 40", imem_addr); end
    tests++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin fails++; $display("FAIL br_bubble got %b/%h exp 0/0", if_id_valid, if_id_instr); end
    tests++; if (if_id_pc !== 32'h8) begin fails++; $display("FAIL br_pc_hold got %h exp 8", if_id_pc); end
    tick();
    tests++; if (if_id_pc !== 32'h40 || if_id_instr !== 32'hA000_0010 || if_id_valid !== 1'b1) begin
      fails++; $display("FAIL br_fetch got %h/%h/%b exp 40/a0000010/1", if_id_pc, if_id_instr, if_id_valid); end
  endtask

  task automatic test_priority();
    branch_taken = 1; branch_target = 32'h80; jump = 1; jump_target = 32'h100;
    tick();
    branch_taken = 0; jump = 0;
    tests++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL br_over_jump got %h exp 80", imem_addr); end
    jump = 1; jump_target = 32'h103;
    tick();
    jump = 0;
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL jump_align got %h exp 100", imem_addr); end
  endtask

  task automatic test_flush();
    flush = 1; stall = 1;
    tick();
    flush = 0; stall = 0;
    tests++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL flush_addr got %h exp 104", imem_addr); end
    tests++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h40) begin fails++; $display("FAIL flush_bubble got %b/%h exp 0/40", if_id_valid, if_id_pc); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    w_rst_n = 1;
    tests++; if (w_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_reset got %h exp fffffffc", w_addr); end
    tick();
    tests++; if (w_addr !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h exp 0", w_addr); end
    tests++; if (w_pc4 !== 32'h0 || w_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_ifid got %h/%h exp 0/fffffffc", w_pc4, w_pc); end
    tests++; if (w_id_instr !== 32'hA000_00FF) begin fails++; $display("FAIL wrap_instr got %h exp a00000ff", w_id_instr); end
  endtask

  task automatic test_async_reset();
    jump = 1; jump_target = 32'h20;
    tick();
    jump = 0;
    tests++; if (imem_addr !== 32'h20) begin fails++; $display("FAIL ar_setup got %h exp 20", imem_addr); end
    stall = 1;
    #2 rst_n = 0;
    #1;
    tests++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin fails++; $display("FAIL async_reset got %h/%b exp 0/0", imem_addr, if_id_valid); end
    stall = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    tests++; if (perf_fetch_cnt !== 0 || perf_bubble_cnt !== 0) begin fails++; $display("FAIL perf_clear got %0d/%0d exp 0/0", perf_fetch_cnt, perf_bubble_cnt); end
    for (int i = 0; i < 5; i++) tick();
    stall = 1;
    tick(); tick();
    stall = 0; flush = 1;
    tick();
    flush = 0;
    tests++; if (perf_fetch_cnt !== 32'd5) begin fails++; $display("FAIL perf_fetch got %0d exp 5", perf_fetch_cnt); end
    tests++; if (perf_bubble_cnt !== 32'd1) begin fails++; $display("FAIL perf_bubble got %0d exp 1", perf_bubble_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    test_reset();
    test_fetch();
    test_stall();
    test_branch_stall();
    test_priority();
    test_flush();
    test_wrap();
    test_async_reset();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
